// File: rtl/fptoint_result_collector.sv
// FP-to-INT result collector: aligns array results, packs INT16 halves
// into 32-bit lanes and queues packed words for register-file write-back.
module fptoint_result_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       cru_fptoint_in,
  input  logic [127:0]     dr_fptoint_d_out,
  input  logic             flush_in,
  output logic             col_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [127:0]     wb_data,
  output logic [1:0]       wb_hmask,
  output logic [CNT_W-1:0] fifo_cnt,
  output logic             ovf_err,
  output logic             idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_HALF_LO = 2'd1;
  localparam logic [1:0] S_HALF_HI = 2'd2;

  logic w_unused_src;
  assign w_unused_src = ^{cru_fptoint_in[3], cru_fptoint_in[1]};

  logic r_stg_vld;
  logic r_stg_prec;
  logic r_stg_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_vld  <= 1'b0;
      r_stg_prec <= 1'b0;
      r_stg_pos  <= 1'b0;
    end else begin
      r_stg_vld  <= cru_fptoint_in[4];
      r_stg_prec <= cru_fptoint_in[2];
      r_stg_pos  <= cru_fptoint_in[0];
    end
  end

  // Selected INT16 half of every lane, kept in its own half position.
  logic [127:0] w_half;
  always_comb begin
    w_half = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_stg_pos)
        w_half[32*i+16 +: 16] = dr_fptoint_d_out[32*i+16 +: 16];
      else
        w_half[32*i +: 16] = dr_fptoint_d_out[32*i +: 16];
    end
  end

  logic [1:0]   r_state;
  logic [127:0] r_pack;
  logic [1:0]   w_state_nx;
  logic [127:0] w_pack_nx;
  logic [1:0]   w_pend_mask;
  logic [1:0]   w_fl_mask;
  logic         w_same_half;
  logic         w_p0_vld;
  logic [127:0] w_p0_data;
  logic [1:0]   w_p0_mask;
  logic         w_p1_vld;
  logic [127:0] w_p1_data;
  logic [1:0]   w_p1_mask;

  assign w_pend_mask = (r_state == S_HALF_HI) ? 2'b10 : 2'b01;
  assign w_same_half = r_stg_pos == (r_state == S_HALF_HI);

  always_comb begin
    w_state_nx = r_state;
    w_pack_nx  = r_pack;
    w_fl_mask  = 2'b00;
    w_p0_vld   = 1'b0;
    w_p0_data  = '0;
    w_p0_mask  = 2'b00;
    w_p1_vld   = 1'b0;
    w_p1_data  = '0;
    w_p1_mask  = 2'b00;
    if (r_stg_vld) begin
      if (r_stg_prec) begin
        if (r_state != S_EMPTY) begin
          w_p0_vld  = 1'b1;
          w_p0_data = r_pack;
          w_p0_mask = w_pend_mask;
          w_p1_vld  = 1'b1;
          w_p1_data = dr_fptoint_d_out;
          w_p1_mask = 2'b11;
        end else begin
          w_p0_vld  = 1'b1;
          w_p0_data = dr_fptoint_d_out;
          w_p0_mask = 2'b11;
        end
        w_state_nx = S_EMPTY;
        w_pack_nx  = '0;
      end else if (r_state == S_EMPTY) begin
        w_pack_nx  = w_half;
        w_state_nx = r_stg_pos ? S_HALF_HI : S_HALF_LO;
      end else if (w_same_half) begin
        w_p0_vld  = 1'b1;
        w_p0_data = r_pack;
        w_p0_mask = w_pend_mask;
        w_pack_nx = w_half;
      end else begin
        w_p0_vld   = 1'b1;
        w_p0_data  = r_pack | w_half;
        w_p0_mask  = 2'b11;
        w_state_nx = S_EMPTY;
        w_pack_nx  = '0;
      end
    end
    // Flush acts on the post-merge state, so it lands after any push above.
    if (flush_in && (w_state_nx != S_EMPTY)) begin
      w_fl_mask = (w_state_nx == S_HALF_HI) ? 2'b10 : 2'b01;
      if (w_p0_vld) begin
        w_p1_vld  = 1'b1;
        w_p1_data = w_pack_nx;
        w_p1_mask = w_fl_mask;
      end else begin
        w_p0_vld  = 1'b1;
        w_p0_data = w_pack_nx;
        w_p0_mask = w_fl_mask;
      end
      w_state_nx = S_EMPTY;
      w_pack_nx  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_pack  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pack  <= w_pack_nx;
    end
  end

  logic [127:0]     r_mem_data [DEPTH];
  logic [1:0]       r_mem_mask [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_pop;
  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_need1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_drop;

  assign wb_valid = r_cnt != '0;
  assign w_pop    = wb_valid && wb_ready;
  // A same-cycle pop frees its slot for this cycle's pushes.
  assign w_free   = DEPTH_C - r_cnt + CNT_W'(w_pop);
  assign w_acc0   = w_p0_vld && (w_free != '0);
  assign w_need1  = w_acc0 ? CNT_W'(2) : CNT_W'(1);
  assign w_acc1   = w_p1_vld && (w_free >= w_need1);
  assign w_drop   = (w_p0_vld && !w_acc0) || (w_p1_vld && !w_acc1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_mask[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_acc0) begin
        r_mem_data[r_wptr] <= w_p0_data;
        r_mem_mask[r_wptr] <= w_p0_mask;
      end
      if (w_acc1) begin
        r_mem_data[r_wptr + AW'(1)] <= w_p1_data;
        r_mem_mask[r_wptr + AW'(1)] <= w_p1_mask;
      end
      r_wptr <= r_wptr + AW'(w_acc0) + AW'(w_acc1);
      r_rptr <= r_rptr + AW'(w_pop);
      r_cnt  <= r_cnt + CNT_W'(w_acc0) + CNT_W'(w_acc1)
              - CNT_W'(w_pop);
      r_ovf  <= r_ovf | w_drop;
    end
  end

  logic [CNT_W-1:0] w_space;
  logic [CNT_W-1:0] w_need_in;

  // Reserve two slots for the staged result and two for a new issue.
  assign w_space   = DEPTH_C - r_cnt;
  assign w_need_in = r_stg_vld ? CNT_W'(4) : CNT_W'(2);
  assign col_ready = w_space >= w_need_in;

  assign wb_data  = r_mem_data[r_rptr];
  assign wb_hmask = r_mem_mask[r_rptr];
  assign fifo_cnt = r_cnt;
  assign ovf_err  = r_ovf;
  assign idle     = (r_cnt == '0) && !r_stg_vld
                 && (r_state == S_EMPTY);

endmodule
